// File: rtl/mm_console_pkg.sv
// Shared definitions for the console master byte protocol: control characters,
// escape mask and the decoder state encoding.
package mm_console_pkg;

  localparam logic [7:0] SOP_CHAR = 8'h7A;
  localparam logic [7:0] EOP_CHAR = 8'h7B;
  localparam logic [7:0] CHN_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR = 8'h7D;
  localparam logic [7:0] ESC_XOR  = 8'h20;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_ESC,
    ST_CHAN,
    ST_CHAN_ESC
  } dec_state_e;

  function automatic logic is_control(input logic [7:0] b);
    return (b == SOP_CHAR) || (b == EOP_CHAR) || (b == CHN_CHAR) || (b == ESC_CHAR);
  endfunction

endpackage

// File: rtl/mm_console_master_bytes_to_packets_if.sv
// Byte-stream input and Avalon-ST packet output of the console byte decoder.
// slave is the decoder's view; master is the surrounding environment.
interface mm_console_master_bytes_to_packets_if;

  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic [7:0] out_channel;

  modport slave (
    output in_ready,
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
  );

  modport master (
    input  in_ready,
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_startofpacket, out_endofpacket, out_channel
  );

endinterface

// File: rtl/mm_console_master_bytes_to_packets.sv
// Decodes the console byte stream (SOP/EOP/channel markers, escapes) into a
// registered Avalon-ST packet stream with a one-entry output register.
module mm_console_master_bytes_to_packets
  import mm_console_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mm_console_master_bytes_to_packets_if.slave st
);

  dec_state_e state;
  logic       sop_pend;
  logic       eop_pend;
  logic [7:0] chan_q;

  logic       accept;
  logic       emit;
  logic [7:0] emit_data;

  // The output register can take a new byte whenever it is empty or draining.
  assign st.in_ready = st.out_ready || !st.out_valid;
  assign accept      = st.in_valid && st.in_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    emit      = 1'b0;
    emit_data = st.in_data;
    if (accept) begin
      unique case (state)
        ST_NORMAL: emit = !is_control(st.in_data);
        ST_ESC: begin
          emit      = 1'b1;
          emit_data = st.in_data ^ ESC_XOR;
        end
        default: emit = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_NORMAL;
      sop_pend <= 1'b0;
      eop_pend <= 1'b0;
      chan_q   <= '0;
    end else if (accept) begin
      unique case (state)
        ST_NORMAL: begin
          case (st.in_data)
            SOP_CHAR: begin
              sop_pend <= 1'b1;
              eop_pend <= 1'b0;
            end
            EOP_CHAR: eop_pend <= 1'b1;
            CHN_CHAR: state    <= ST_CHAN;
            ESC_CHAR: state    <= ST_ESC;
            default: begin
              sop_pend <= 1'b0;
              eop_pend <= 1'b0;
            end
          endcase
        end
        ST_ESC: begin
          sop_pend <= 1'b0;
          eop_pend <= 1'b0;
          state    <= ST_NORMAL;
        end
        ST_CHAN: begin
          if (st.in_data == ESC_CHAR) begin
            state <= ST_CHAN_ESC;
          end else begin
            chan_q <= st.in_data;
            state  <= ST_NORMAL;
          end
        end
        ST_CHAN_ESC: begin
          chan_q <= st.in_data ^ ESC_XOR;
          state  <= ST_NORMAL;
        end
      endcase
    end
  end

  // NOTE: the output register is cleared on reset so a held byte never survives it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st.out_valid         <= 1'b0;
      st.out_data          <= '0;
      st.out_startofpacket <= 1'b0;
      st.out_endofpacket   <= 1'b0;
      st.out_channel       <= '0;
    end else if (emit) begin
      // The channel tag is sampled here, so a later channel change cannot retag a held byte.
      st.out_valid         <= 1'b1;
      st.out_data          <= emit_data;
      st.out_startofpacket <= sop_pend;
      st.out_endofpacket   <= eop_pend;
      st.out_channel       <= chan_q;
    end else if (st.out_ready) begin
      st.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mm_console_master_bytes_to_packets.sv
// Randomized bench for the console byte decoder, checked against a stream-level
// reference model that turns a whole byte list into the expected packet bytes.
module tb_mm_console_master_bytes_to_packets;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [7:0] ch;
    int         src;
  } pkt_byte_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mm_console_master_bytes_to_packets_if bus();

  mm_console_master_bytes_to_packets dut (
    .clk   (clk),
    .reset (reset),
    .st    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: protocol position, pending flags, current channel.
  bit         m_esc, m_chan, m_chan_esc, m_sop, m_eop;
  logic [7:0] m_ch;
  pkt_byte_t  exp_q[$];

  function automatic void model_reset();
    m_esc = 0; m_chan = 0; m_chan_esc = 0; m_sop = 0; m_eop = 0;
    m_ch = 8'h00;
    exp_q.delete();
  endfunction

  function automatic void model_emit(input logic [7:0] v, input int idx);
    pkt_byte_t p;
    p.data = v; p.sop = m_sop; p.eop = m_eop; p.ch = m_ch; p.src = idx;
    exp_q.push_back(p);
    m_sop = 0; m_eop = 0;
  endfunction

  function automatic void model_feed(input logic [7:0] b, input int idx);
    if (m_chan_esc) begin
      m_ch = b ^ 8'h20;
      m_chan_esc = 0;
    end else if (m_chan) begin
      m_chan = 0;
      if (b == 8'h7D) m_chan_esc = 1;
      else m_ch = b;
    end else if (m_esc) begin
      m_esc = 0;
      model_emit(b ^ 8'h20, idx);
    end else begin
      case (b)
        8'h7A:   begin m_sop = 1; m_eop = 0; end
        8'h7B:   m_eop = 1;
        8'h7C:   m_chan = 1;
        8'h7D:   m_esc = 1;
        default: model_emit(b, idx);
      endcase
    end
  endfunction

  // Drives a byte list, checks every output handshake, stall stability,
  // in_ready and the one-cycle latency, then drains the output register.
  task automatic run_stream(input string name, input logic [7:0] bytes[$],
                            input int ready_pct, input int valid_pct,
                            input int stall_at, input int stall_len);
    int        acc_cyc[];
    int        i = 0;
    int        cyc = 0;
    int        budget;
    bit        rdy, vld, prev_stall = 0;
    pkt_byte_t held;
    pkt_byte_t e;
    acc_cyc = new[bytes.size()];
    budget  = bytes.size() * 20 + 100;
    for (int k = 0; k < bytes.size(); k++) model_feed(bytes[k], k);

    while ((i < bytes.size() || exp_q.size() > 0 || prev_stall) && cyc < budget) begin
      @(negedge clk);
      if (cyc >= stall_at && cyc < stall_at + stall_len) rdy = 0;
      else if (i >= bytes.size()) rdy = 1;
      else rdy = ($urandom_range(99) < ready_pct);
      vld = (i < bytes.size()) && ($urandom_range(99) < valid_pct);
      bus.out_ready = rdy;
      bus.in_valid  = vld;
      bus.in_data   = vld ? bytes[i] : 8'($urandom);
      #1;
      checks++;
      if (bus.in_ready !== (rdy || !bus.out_valid)) begin
        failures++;
        $display("FAIL %s in_ready cyc=%0d got=%b out_valid=%b out_ready=%b", name, cyc,
                 bus.in_ready, bus.out_valid, rdy);
      end
      if (bus.out_valid === 1'b1) begin
        if (prev_stall) begin
          checks++;
          if (bus.out_data !== held.data || bus.out_startofpacket !== held.sop ||
              bus.out_endofpacket !== held.eop || bus.out_channel !== held.ch) begin
            failures++;
            $display("FAIL %s stall_stable cyc=%0d got=%h/%b/%b/%h held=%h/%b/%b/%h", name, cyc,
                     bus.out_data, bus.out_startofpacket, bus.out_endofpacket, bus.out_channel,
                     held.data, held.sop, held.eop, held.ch);
          end
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s unexpected_output cyc=%0d got=%h expected none", name, cyc,
                   bus.out_data);
        end else begin
          e = exp_q[0];
          if (!prev_stall) begin
            checks++;
            if (cyc !== acc_cyc[e.src] + 1) begin
              failures++;
              $display("FAIL %s latency byte=%0d got_cycle=%0d expected_cycle=%0d", name,
                       e.src, cyc, acc_cyc[e.src] + 1);
            end
          end
          if (bus.out_data !== e.data || bus.out_startofpacket !== e.sop ||
              bus.out_endofpacket !== e.eop || bus.out_channel !== e.ch) begin
            failures++;
            $display("FAIL %s output byte=%0d got d=%h sop=%b eop=%b ch=%h expected d=%h sop=%b eop=%b ch=%h",
                     name, e.src, bus.out_data, bus.out_startofpacket, bus.out_endofpacket,
                     bus.out_channel, e.data, e.sop, e.eop, e.ch);
          end
          if (rdy) void'(exp_q.pop_front());
        end
        held.data = bus.out_data; held.sop = bus.out_startofpacket;
        held.eop = bus.out_endofpacket; held.ch = bus.out_channel;
      end
      prev_stall = (bus.out_valid === 1'b1) && !rdy;
      if (vld && bus.in_ready === 1'b1) begin
        acc_cyc[i] = cyc;
        i++;
      end
      cyc++;
    end

    @(negedge clk);
    bus.in_valid  = 0;
    bus.out_ready = 1;
    #1;
    checks++;
    if (i != bytes.size() || exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s completion consumed=%0d of %0d pending_expected=%0d out_valid=%b", name,
               i, bytes.size(), exp_q.size(), bus.out_valid);
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_startofpacket !== 1'b0 ||
        bus.out_endofpacket !== 1'b0 || bus.out_channel !== 8'h00) begin
      failures++;
      $display("FAIL %s reset_outputs got v=%b d=%h sop=%b eop=%b ch=%h expected all zero", name,
               bus.out_valid, bus.out_data, bus.out_startofpacket, bus.out_endofpacket,
               bus.out_channel);
    end
  endtask

  task automatic drive_raw(input logic [7:0] b, input bit ordy);
    @(negedge clk);
    bus.in_valid  = 1;
    bus.in_data   = b;
    bus.out_ready = ordy;
  endtask

  task automatic test_reset();
    reset = 1;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset in_ready got=%b expected=1", bus.in_ready);
    end
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic test_basic();
    run_stream("basic", '{8'h7A, 8'h7C, 8'h00, 8'h11, 8'h22, 8'h7B, 8'h33}, 100, 100, -1, 0);
  endtask

  task automatic test_escapes();
    run_stream("escapes", '{8'h7A, 8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7B, 8'h7D, 8'h5C}, 100, 100, -1, 0);
  endtask

  task automatic test_channel();
    run_stream("channel", '{8'h7C, 8'h7D, 8'h5B, 8'h7A, 8'h44, 8'h7B, 8'h55,
                            8'h7C, 8'h05, 8'h7A, 8'h66, 8'h7B, 8'h77}, 100, 100, -1, 0);
  endtask

  task automatic test_edges();
    run_stream("edges_repeat", '{8'h7A, 8'h7A, 8'h7B, 8'h7A, 8'h88}, 100, 100, -1, 0);
    run_stream("edges_single", '{8'h7A, 8'h7B, 8'h99}, 100, 100, -1, 0);
    run_stream("edges_eop_only", '{8'h7B, 8'h7D, 8'h5B, 8'h12}, 100, 100, -1, 0);
  endtask

  task automatic test_backpressure();
    logic [7:0] pkt[$];
    pkt = '{8'h7A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h7B, 8'h08};
    run_stream("stall5", pkt, 100, 100, 3, 5);
    // Random traffic biased toward control characters, long enough to exercise every state.
    pkt.delete();
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(4) == 0) pkt.push_back(8'h7A + 8'($urandom_range(3)));
      else pkt.push_back(8'($urandom));
    end
    run_stream("random_raw", pkt, 50, 70, -1, 0);
    pkt.delete();
    for (int p = 0; p < 30; p++) begin
      pkt.push_back(8'h7C);
      pkt.push_back(8'($urandom_range(255)));
      pkt.push_back(8'h7A);
      for (int k = 0; k < 30; k++) begin
        logic [7:0] d;
        d = 8'($urandom);
        if (k == 29) pkt.push_back(8'h7B);
        if (d >= 8'h7A && d <= 8'h7D) begin
          pkt.push_back(8'h7D);
          pkt.push_back(d ^ 8'h20);
        end else begin
          pkt.push_back(d);
        end
      end
    end
    run_stream("random_packets", pkt, 40, 80, -1, 0);
  endtask

  task automatic test_reset_midstream();
    drive_raw(8'h7C, 0);
    drive_raw(8'h3C, 0);
    drive_raw(8'h7A, 0);
    drive_raw(8'h11, 0);
    @(negedge clk);
    bus.in_valid = 0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.out_channel !== 8'h3C ||
        bus.out_startofpacket !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid held_byte got v=%b d=%h ch=%h sop=%b expected v=1 d=11 ch=3c sop=1",
               bus.out_valid, bus.out_data, bus.out_channel, bus.out_startofpacket);
    end
    #1 reset = 1;
    #1;
    check_outputs_zero("reset_mid_held");
    @(negedge clk);
    reset = 0;
    model_reset();
    drive_raw(8'h7A, 1);
    drive_raw(8'h7D, 1);
    @(negedge clk);
    bus.in_valid = 0;
    #2 reset = 1;
    #1;
    check_outputs_zero("reset_mid_esc");
    @(negedge clk);
    reset = 0;
    model_reset();
    run_stream("after_reset", '{8'h7D, 8'h5A}, 100, 100, -1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_escapes();
    test_channel();
    test_edges();
    test_backpressure();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
